// File: rtl/chip_store_pkg.sv
// Shared constants for the synchro counter: parameter defaults and direction encoding.
package chip_store_pkg;

  localparam int WIDTH_DEF      = 8;
  localparam int PRESCALE_W_DEF = 30;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tick_source.sv
// Single-cycle count tick from either a free-running prescaler or a count_in rising edge.
module tick_source
  import chip_store_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  qzt_clk,
  input  logic                  reset,
  input  logic                  count_in,
  input  logic                  use_prescaler,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] period,
  output logic                  tick
);

  logic                  count_in_old;
  logic                  use_old;
  logic [PRESCALE_W-1:0] presc;
  logic                  mode_chg;
  logic                  presc_hit;
  logic                  ext_tick;

  assign mode_chg  = use_prescaler ^ use_old;
  // Periods 0 and 1 both mean "every cycle"; >= keeps a shrinking period from overrunning.
  assign presc_hit = (period <= PRESCALE_W'(1)) || (presc >= (period - PRESCALE_W'(1)));
  assign ext_tick  = count_in & ~count_in_old;

  // Edge and mode history track their inputs even in reset, so release never sees a stale edge.
  always_ff @(posedge qzt_clk) begin
    count_in_old <= count_in;
    use_old      <= use_prescaler;
    if (reset || mode_chg || !use_prescaler)
      presc <= '0;
    else if (enable)
      presc <= presc_hit ? '0 : presc + PRESCALE_W'(1);
  end

  assign tick = ~reset & ~mode_chg &
                (use_prescaler ? (enable & presc_hit) : ext_tick);

endmodule

// File: rtl/synchro_counter_updown.sv
// Modulo-M up/down counter with preset, wrap carry and terminal flag; ticks come from tick_source.
module synchro_counter_updown
  import chip_store_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  qzt_clk,
  input  logic                  reset,
  input  logic                  count_in,
  input  logic                  use_prescaler,
  input  logic [PRESCALE_W-1:0] period,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  set,
  input  logic [WIDTH-1:0]      preset_value,
  input  logic [WIDTH-1:0]      limit,
  output logic [WIDTH-1:0]      out,
  output logic                  carry,
  output logic                  terminal
);

  logic             tick;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] out_nxt;
  logic             carry_nxt;
  logic             term_nxt;

  tick_source #(
    .PRESCALE_W (PRESCALE_W)
  ) u_tick_source (
    .qzt_clk       (qzt_clk),
    .reset         (reset),
    .count_in      (count_in),
    .use_prescaler (use_prescaler),
    .enable        (enable),
    .period        (period),
    .tick          (tick)
  );

  // limit==0 selects the full 2^WIDTH range, whose top value is all ones.
  assign max_val = (limit == '0) ? '1 : limit - WIDTH'(1);

  always_comb begin
    out_nxt   = out;
    carry_nxt = 1'b0;
    if (set) begin
      out_nxt = preset_value;
    end else if (tick && enable) begin
      if (up_down == DIR_UP) begin
        if (out >= max_val) begin
          out_nxt   = '0;
          carry_nxt = 1'b1;
        end else begin
          out_nxt = out + WIDTH'(1);
        end
      end else begin
        // An out-of-range value (e.g. a large preset) clamps to the top without a borrow.
        if (out == '0) begin
          out_nxt   = max_val;
          carry_nxt = 1'b1;
        end else if (out > max_val) begin
          out_nxt = max_val;
        end else begin
          out_nxt = out - WIDTH'(1);
        end
      end
    end
    term_nxt = (up_down == DIR_UP) ? (out_nxt == max_val) : (out_nxt == '0);
  end

  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      out      <= '0;
      carry    <= 1'b0;
      terminal <= (up_down == DIR_DOWN);
    end else begin
      out      <= out_nxt;
      carry    <= carry_nxt;
      terminal <= term_nxt;
    end
  end

endmodule
